// File: rtl/framebuffer_stream_receiver.sv
// framebuffer_stream_receiver: locks on sync, tracks segment framing and deserializes 30 lanes into groups.
// Optional FB_RX_PATTERN_CHECK_EN adds a sticky pattern_err output for the B,G,R test stream.
module framebuffer_stream_receiver #(
    parameter int SEGMENT_CYCLES  = 513,
    parameter int BLANKING_CYCLES = 72,
    parameter int GROUP_LEN       = 48,
    parameter int GAP_CYCLES      = 1,
    parameter int MUX_COUNT       = 8
) (
    input  logic                    clk_33,
    input  logic                    nrst,
    input  logic [29:0]             data,
    input  logic                    sync,
    output logic [30*GROUP_LEN-1:0] group_data,
    output logic                    group_valid,
    output logic [3:0]              group_index,
    output logic [2:0]              mux_index,
    output logic                    locked,
    output logic                    sync_err
`ifdef FB_RX_PATTERN_CHECK_EN
    ,
    output logic                    pattern_err
`endif
);
    localparam int SEG_W  = $clog2(SEGMENT_CYCLES);
    localparam int BIT_W  = $clog2(GROUP_LEN + GAP_CYCLES);
    localparam int GROUPS = (SEGMENT_CYCLES - BLANKING_CYCLES) / (GROUP_LEN + GAP_CYCLES);

    typedef enum logic [1:0] {UNLOCK, BLANK, DATA, GAP} state_t;

    state_t                    state_q, state_d;
    logic [SEG_W-1:0]          seg_cnt_q, seg_cnt_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]                grp_q, grp_d;
    logic [2:0]                mux_q, mux_d;
    logic [GROUP_LEN-2:0]      shift_q [30];
    logic [GROUP_LEN-2:0]      shift_d [30];
    logic [30*GROUP_LEN-1:0]   group_data_q, group_data_d;
    logic                      group_valid_q, group_valid_d;
    logic [3:0]                group_index_q, group_index_d;
    logic                      locked_q, locked_d;
    logic                      sync_err_q, sync_err_d;
    logic                      last_data, wrap, slot;
`ifdef FB_RX_PATTERN_CHECK_EN
    logic                      pattern_err_q, pattern_err_d;
    logic [2:0]                ph_q, ph_d;
`endif

    assign last_data = state_q == DATA && bit_cnt_q == BIT_W'(GROUP_LEN - 1);
    assign wrap      = seg_cnt_q == SEG_W'(SEGMENT_CYCLES - 1);
    assign slot      = wrap && mux_q == 3'(MUX_COUNT - 1);

    always_comb begin
        state_d       = state_q;
        seg_cnt_d     = seg_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        grp_d         = grp_q;
        mux_d         = mux_q;
        shift_d       = shift_q;
        group_data_d  = group_data_q;
        group_valid_d = 1'b0;
        group_index_d = group_index_q;
        locked_d      = locked_q;
        sync_err_d    = 1'b0;
        if (state_q == DATA)
            for (int l = 0; l < 30; l++) shift_d[l] = {shift_q[l][GROUP_LEN-3:0], data[l]};
        // Any sync on the closing data cycle is unexpected, so the group is dropped
        if (last_data && !sync) begin
            group_valid_d = 1'b1;
            group_index_d = grp_q;
            for (int l = 0; l < 30; l++) group_data_d[l*GROUP_LEN +: GROUP_LEN] = {shift_q[l], data[l]};
        end
        if (state_q == UNLOCK) begin
            if (sync) begin
                state_d   = BLANK;
                locked_d  = 1'b1;
                seg_cnt_d = '0;
                mux_d     = '0;
            end
        end else if (sync && !slot) begin
            sync_err_d = 1'b1;
            state_d    = BLANK;
            seg_cnt_d  = '0;
            mux_d      = '0;
        end else if (wrap) begin
            seg_cnt_d = '0;
            if (slot && !sync) begin
                sync_err_d = 1'b1;
                locked_d   = 1'b0;
                state_d    = UNLOCK;
                mux_d      = '0;
            end else begin
                state_d = BLANK;
                mux_d   = slot ? 3'd0 : mux_q + 3'd1;
            end
        end else begin
            seg_cnt_d = seg_cnt_q + SEG_W'(1);
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (state_q == BLANK && seg_cnt_q == SEG_W'(BLANKING_CYCLES - 1)) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                grp_d     = '0;
            end else if (last_data) begin
                state_d   = GAP;
                bit_cnt_d = '0;
            end else if (state_q == GAP && bit_cnt_q == BIT_W'(GAP_CYCLES - 1) && grp_q < 4'(GROUPS - 1)) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                grp_d     = grp_q + 4'd1;
            end
        end
    end

`ifdef FB_RX_PATTERN_CHECK_EN
    // Words must be all-zero or all-one, and the all-one cycles repeat every third data cycle
    always_comb begin
        pattern_err_d = pattern_err_q;
        ph_d          = ph_q;
        if (state_q == DATA) begin
            ph_d = {ph_q[1:0], &data};
            if ((|data && !(&data)) || (bit_cnt_q >= BIT_W'(3) && (&data) != ph_q[2]))
                pattern_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            pattern_err_q <= 1'b0;
            ph_q          <= '0;
        end else begin
            pattern_err_q <= pattern_err_d;
            ph_q          <= ph_d;
        end
    end

    assign pattern_err = pattern_err_q;
`endif

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            state_q       <= UNLOCK;
            seg_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            grp_q         <= '0;
            mux_q         <= '0;
            shift_q       <= '{default: '0};
            group_data_q  <= '0;
            group_valid_q <= 1'b0;
            group_index_q <= '0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            seg_cnt_q     <= seg_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            grp_q         <= grp_d;
            mux_q         <= mux_d;
            shift_q       <= shift_d;
            group_data_q  <= group_data_d;
            group_valid_q <= group_valid_d;
            group_index_q <= group_index_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign group_data  = group_data_q;
    assign group_valid = group_valid_q;
    assign group_index = group_index_q;
    assign mux_index   = mux_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_framebuffer_stream_receiver.sv
// tb_framebuffer_stream_receiver: random stream against a positional reference model plus literal checks.
module tb_framebuffer_stream_receiver;
    logic           clk_33 = 1'b0;
    logic           nrst = 1'b0;
    logic [29:0]    data = '0;
    logic           sync = 1'b0;
    logic [1439:0]  group_data;
    logic           group_valid;
    logic [3:0]     group_index;
    logic [2:0]     mux_index;
    logic           locked;
    logic           sync_err;
`ifdef FB_RX_PATTERN_CHECK_EN
    logic           pattern_err;
`endif

    framebuffer_stream_receiver dut (
        .clk_33(clk_33), .nrst(nrst), .data(data), .sync(sync),
        .group_data(group_data), .group_valid(group_valid), .group_index(group_index),
        .mux_index(mux_index), .locked(locked), .sync_err(sync_err)
`ifdef FB_RX_PATTERN_CHECK_EN
        , .pattern_err(pattern_err)
`endif
    );

    always #5 clk_33 = ~clk_33;

    int total = 0, bad = 0, cyc = 0, valid_cyc = 0, nvalid = 0, nerr = 0;
    always @(posedge clk_33) cyc++;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
        end
    endtask

    // Reference: stream position since alignment; segment/group/bit follow by division
    bit            m_locked;
    int            m_p;
    logic [1439:0] m_work, exp_gd;
    bit            exp_valid, exp_err, exp_pat;
    int            exp_gidx, exp_mux;
    bit            hist [48];

    always @(posedge clk_33 or negedge nrst) begin : model
        int seg, g, b;
        bit slot, ones;
        if (!nrst) begin
            m_locked = 0; m_p = 0; exp_gd = '0; exp_valid = 0; exp_err = 0;
            exp_gidx = 0; exp_mux = 0; exp_pat = 0;
        end else begin
            exp_valid = 0;
            exp_err   = 0;
            seg  = m_p % 513;
            g    = (seg - 72) / 49;
            b    = (seg - 72) % 49;
            slot = m_locked && seg == 512 && m_p / 513 == 7;
            if (m_locked && seg >= 72 && b < 48 && g < 9) begin
                ones = data == '1;
                if ((data != 0 && !ones) || (b >= 3 && ones != hist[b-3])) exp_pat = 1;
                hist[b] = ones;
                if (!sync) begin
                    for (int l = 0; l < 30; l++) m_work[l*48 + 47 - b] = data[l];
                    if (b == 47) begin
                        exp_valid = 1;
                        exp_gd    = m_work;
                        exp_gidx  = g;
                    end
                end
            end
            if (!m_locked) begin
                if (sync) begin m_locked = 1; m_p = 0; end
            end else if (sync != slot) begin
                exp_err = 1;
                m_p     = 0;
                if (!sync) m_locked = 0;
            end else begin
                m_p = slot ? 0 : m_p + 1;
            end
            exp_mux = m_p / 513;
        end
    end

    always @(negedge clk_33) begin
        chk("valid", 64'(group_valid), 64'(exp_valid));
        chk("index", 64'(group_index), 64'(exp_gidx));
        chk("mux", 64'(mux_index), 64'(exp_mux));
        chk("locked", 64'(locked), 64'(m_locked));
        chk("sync_err", 64'(sync_err), 64'(exp_err));
`ifdef FB_RX_PATTERN_CHECK_EN
        chk("pattern_err", 64'(pattern_err), 64'(exp_pat));
`endif
        total++;
        if (group_data !== exp_gd) begin
            bad++;
            for (int l = 0; l < 30; l++)
                if (group_data[l*48 +: 48] !== exp_gd[l*48 +: 48]) begin
                    $display("FAIL group_data cyc=%0d lane=%0d got=%0h exp=%0h", cyc, l,
                             group_data[l*48 +: 48], exp_gd[l*48 +: 48]);
                    break;
                end
        end
        if (group_valid) begin nvalid++; valid_cyc = cyc; end
        if (sync_err) nerr++;
    end

    task automatic tick(input logic [29:0] d, input logic s);
        data = d;
        sync = s;
        @(posedge clk_33);
        #2;
    endtask

    function automatic logic [29:0] bgr(input int j);
        return (j >= 72 && (j - 72) % 49 < 48 && ((j - 72) % 49) % 3 == 0) ? '1 : '0;
    endfunction

    int n, n0, e0;

    initial begin
        repeat (3) @(posedge clk_33);
        #2 nrst = 1'b1;
        repeat (5) tick('0, 0);
        chk("unlocked_after_reset", 64'(locked), 64'd0);
        chk("no_valid_after_reset", 64'(group_valid), 64'd0);

        // Lock, one lane-0 bit on the first data cycle, then a full silent period
        n0 = nvalid; e0 = nerr;
        tick('0, 1);
        for (int j = 0; j < 4104; j++) begin
            tick(j == 72 ? 30'h1 : 30'h0, j == 4103);
            if (j == 119) begin
                chk("g0_valid", 64'(group_valid), 64'd1);
                chk("g0_lane0", group_data[63:0], 64'h0000_8000_0000_0000);
                chk("g0_rest_zero", 64'(|group_data[1439:64]), 64'd0);
                chk("g0_index", 64'(group_index), 64'd0);
            end
        end
        chk("valid_per_period", 64'(nvalid - n0), 64'd72);
        chk("no_err_in_period", 64'(nerr - e0), 64'd0);
        chk("locked_after_period", 64'(locked), 64'd1);

        // Random period with the expected sync, then an extra sync at seg 200
        for (int j = 0; j < 4104; j++) tick(30'($urandom), j == 4103);
        for (int j = 0; j < 200; j++) tick(30'($urandom), 0);
        e0 = nerr;
        n = cyc;
        tick(30'($urandom), 1);
        for (int j = 0; j < 4104; j++) begin
            tick(30'($urandom), 0);
            if (j == 1) chk("extra_sync_err", 64'(nerr - e0), 64'd1);
            if (j == 130) chk("realign_latency", 64'(valid_cyc - n), 64'd121);
        end
        chk("missing_sync_err", 64'(sync_err), 64'd1);
        chk("missing_sync_unlock", 64'(locked), 64'd0);
        n0 = nvalid;
        repeat (600) tick(30'($urandom), 0);
        chk("no_valid_unlocked", 64'(nvalid - n0), 64'd0);

        // Reset in the middle of a group, then relock with a B,G,R stream
        tick('0, 1);
        for (int j = 0; j < 100; j++) tick(30'($urandom), 0);
        #1 nrst = 1'b0;
        #1;
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_data", 64'(|group_data), 64'd0);
        chk("rst_mux", 64'(mux_index), 64'd0);
        repeat (2) tick('0, 0);
        nrst = 1'b1;
        tick('0, 0);
        n = cyc;
        tick('0, 1);
        for (int j = 0; j <= 130; j++) tick(bgr(j), 0);
        chk("post_reset_latency", 64'(valid_cyc - n), 64'd121);
`ifdef FB_RX_PATTERN_CHECK_EN
        chk("bgr_no_pattern_err", 64'(pattern_err), 64'd0);
        tick(30'h1, 0);
        tick('0, 0);
        chk("pattern_err_set", 64'(pattern_err), 64'd1);
        repeat (20) tick('0, 0);
        chk("pattern_err_sticky", 64'(pattern_err), 64'd1);
`endif

        // Random data with sparse random syncs
        for (int j = 0; j < 3000; j++) tick(30'($urandom), $urandom_range(0, 399) == 0);
        repeat (3) tick('0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
